result_packer: RTL
==================

RESULT_PACKER -- requirements
Module: result_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, input word width in bits.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 16, idle cycles before a half-filled pair is flushed; legal range 1..255.
REQ-003 SHALL have parameter PAD_WORD, default 32'hFFFF_FFFF, filler for the upper half of a flushed pair.
REQ-004 SHALL have port clock  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_empty  input  1  upstream result FIFO empty.
REQ-007 SHALL have port in_rd  output  1  one-cycle read strobe to upstream FIFO.
REQ-008 SHALL have port in_din  input  DATA_WIDTH  upstream FIFO read data.
REQ-009 SHALL have port out_full  input  1  downstream FIFO full.
REQ-010 SHALL have port out_wr  output  1  one-cycle write strobe to downstream FIFO.
REQ-011 SHALL have port out_dout  output  2*DATA_WIDTH  packed pair {upper, lower}.
REQ-012 SHALL have port word_count  output  32  words consumed since reset, wraps mod 2^32.
REQ-013 SHALL have port checksum  output  DATA_WIDTH  sum of consumed words, wraps mod 2^DATA_WIDTH.
REQ-014 SHALL have port flush_count  output  16  padded pairs emitted, saturates at 16'hFFFF.

Function
REQ-015 SHALL implement FSM states IDLE, RD_WAIT, CAPTURE, EMIT.
REQ-016 IDLE: when !in_empty and no pair pending emission, SHALL pulse in_rd for exactly one cycle and go to RD_WAIT.
REQ-017 RD_WAIT SHALL last one cycle then go to CAPTURE; in_din is valid in CAPTURE (read latency: sampled two edges after the in_rd edge).
REQ-018 CAPTURE: if no lower half held, SHALL store in_din as lower half, return to IDLE; else SHALL store as upper half and go to EMIT.
REQ-019 Every captured word SHALL increment word_count by 1 and add into checksum in the CAPTURE cycle.
REQ-020 EMIT: while out_full=1 SHALL hold out_dout stable with out_wr=0; first cycle out_full=0 SHALL pulse out_wr for one cycle, clear the held pair, go to IDLE.
REQ-021 in_rd and out_wr SHALL never be high for more than one consecutive cycle and SHALL never be high in the same cycle.
REQ-022 Idle counter SHALL count cycles in IDLE with a lower half held and in_empty=1; resets to 0 on any in_rd.
REQ-023 When idle counter reaches FLUSH_CYCLES, SHALL form {PAD_WORD, lower} and go to EMIT; flush_count increments on that pair's out_wr.
REQ-024 If in_empty falls in the same cycle the idle counter reaches FLUSH_CYCLES, flush SHALL take priority; the new word becomes the lower half of the next pair.
REQ-025 Output pair ordering SHALL equal input order: first-read word in out_dout[DATA_WIDTH-1:0].
REQ-026 No input word SHALL be dropped or duplicated under any pattern of in_empty/out_full.
REQ-027 out_dout SHALL change only on entry to EMIT; SHALL otherwise hold its last value.

Reset
REQ-028 Assertion of reset_n=0 SHALL asynchronously force state IDLE, in_rd=0, out_wr=0, out_dout=0, word_count=0, checksum=0, flush_count=0, idle counter=0, held halves cleared.
REQ-029 Reset mid-operation (RD_WAIT, CAPTURE, EMIT) SHALL discard any held or in-flight word with no write issued.
REQ-030 After deassertion, first in_rd SHALL occur no earlier than the second rising edge.

Structure
REQ-031 State encoding localparams and default DATA_WIDTH SHALL live in shared package cl_stream_pkg, reused by neighbouring stages.
REQ-032 Flush idle counter SHALL be sub-module idle_timer (load-clear, enable, terminal-count output, width 8).

Verification
REQ-033 Reset then words 1,2,3,4 with out_full=0 -> two writes 0x00000002_00000001, 0x00000004_00000003; word_count=4, checksum=10.
REQ-034 Single word 0xA5 then in_empty=1 for 20 cycles -> one write 0xFFFFFFFF_000000A5 exactly FLUSH_CYCLES idle cycles after capture; flush_count=1.
REQ-035 Words 5,6 with out_full=1 for 10 cycles -> out_dout held, out_wr=0 throughout, one write 0x00000006_00000005 on cycle after out_full falls; no in_rd while held.
REQ-036 Checksum wrap: words 0xFFFFFFFF, 0x00000002 -> checksum=0x00000001, word_count=2.
REQ-037 reset_n pulsed low during EMIT with out_full=1 -> out_wr never asserts, all counters 0, next words 7,8 -> write 0x00000008_00000007.
REQ-038 Random in_empty/out_full over 1000 words vs scoreboard -> exact order, no loss/duplication, in_rd and out_wr never concurrent.

Source files
------------

// File: rtl/cl_stream_pkg.sv
// Shared definitions for the result-stream pipeline stages: default word width,
// packer state encoding and small counter helpers.
package cl_stream_pkg;

    localparam int CL_DATA_WIDTH = 32;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT_ENC = 2'd1;
    localparam logic [1:0] ST_CAPTURE_ENC = 2'd2;
    localparam logic [1:0] ST_EMIT_ENC    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_RD_WAIT = ST_RD_WAIT_ENC,
        ST_CAPTURE = ST_CAPTURE_ENC,
        ST_EMIT    = ST_EMIT_ENC
    } packer_state_e;

    // Saturating 16-bit increment used for event counters that must not wrap.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Idle cycle counter: clear has priority over enable, terminal flags that the
// count has reached LIMIT. The counter stops advancing once terminal is seen.
module idle_timer #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [WIDTH-1:0] LIMIT_C = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);

    logic [WIDTH-1:0] count_r;

    // Count register: async reset, clear on demand, advance while enabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LIMIT_C)) begin
            count_r <= count_r + ONE_C;
        end
    end

    assign terminal = (count_r == LIMIT_C);

endmodule

// File: rtl/result_packer.sv
// Packs pairs of result words from an upstream FIFO into double-width writes to a
// downstream FIFO, flushing a lone word with PAD_WORD after a quiet period.
module result_packer
    import cl_stream_pkg::*;
#(
    parameter int                    DATA_WIDTH   = CL_DATA_WIDTH,
    parameter int                    FLUSH_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_WORD     = {DATA_WIDTH{1'b1}}
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_empty,
    output logic                      in_rd,
    input  logic [DATA_WIDTH-1:0]     in_din,
    input  logic                      out_full,
    output logic                      out_wr,
    output logic [2*DATA_WIDTH-1:0]   out_dout,
    output logic [31:0]               word_count,
    output logic [DATA_WIDTH-1:0]     checksum,
    output logic [15:0]               flush_count
);

    packer_state_e state_r;
    packer_state_e state_next_s;

    logic                    ready_r;
    logic [DATA_WIDTH-1:0]   lower_r;
    logic                    lower_valid_r;
    logic                    pair_flush_r;
    logic [2*DATA_WIDTH-1:0] out_dout_r;
    logic [31:0]             word_count_r;
    logic [DATA_WIDTH-1:0]   checksum_r;
    logic [15:0]             flush_count_r;

    logic rd_s;
    logic wr_s;
    logic flush_s;
    logic capture_lo_s;
    logic capture_hi_s;
    logic timer_tc_s;
    logic timer_en_s;
    logic timer_clr_s;

    idle_timer #(
        .WIDTH (8),
        .LIMIT (FLUSH_CYCLES)
    ) u_idle_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (timer_clr_s),
        .enable   (timer_en_s),
        .terminal (timer_tc_s)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and strobe decode; a pending flush outranks a new read.
    always_comb begin
        state_next_s = state_r;
        rd_s         = 1'b0;
        wr_s         = 1'b0;
        flush_s      = 1'b0;
        capture_lo_s = 1'b0;
        capture_hi_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (lower_valid_r && timer_tc_s) begin
                    flush_s      = 1'b1;
                    state_next_s = ST_EMIT;
                end else if (!in_empty && ready_r) begin
                    rd_s         = 1'b1;
                    state_next_s = ST_RD_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                state_next_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (lower_valid_r) begin
                    capture_hi_s = 1'b1;
                    state_next_s = ST_EMIT;
                end else begin
                    capture_lo_s = 1'b1;
                    state_next_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (!out_full) begin
                    wr_s         = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_EMIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Idle timer control: only quiet IDLE cycles with a lone word held count.
    always_comb begin
        timer_en_s  = (state_r == ST_IDLE) && lower_valid_r && in_empty && !timer_tc_s;
        timer_clr_s = rd_s || flush_s;
    end

    // Datapath: held lower half, output pair and statistics.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_r       <= 1'b0;
            lower_r       <= '0;
            lower_valid_r <= 1'b0;
            pair_flush_r  <= 1'b0;
            out_dout_r    <= '0;
            word_count_r  <= 32'd0;
            checksum_r    <= '0;
            flush_count_r <= 16'd0;
        end else begin
            ready_r <= 1'b1;
            if (capture_lo_s) begin
                lower_r       <= in_din;
                lower_valid_r <= 1'b1;
            end
            if (capture_hi_s) begin
                out_dout_r    <= {in_din, lower_r};
                lower_valid_r <= 1'b0;
                pair_flush_r  <= 1'b0;
            end
            if (flush_s) begin
                out_dout_r    <= {PAD_WORD, lower_r};
                lower_valid_r <= 1'b0;
                pair_flush_r  <= 1'b1;
            end
            if (capture_lo_s || capture_hi_s) begin
                word_count_r <= word_count_r + 32'd1;
                checksum_r   <= checksum_r + in_din;
            end
            if (wr_s && pair_flush_r) begin
                flush_count_r <= sat_inc16(flush_count_r);
            end
        end
    end

    // The FIFO strobes must be decided in the same cycle as empty/full, so they
    // are decoded from the registered state rather than registered themselves.
    assign in_rd       = rd_s;
    assign out_wr      = wr_s;
    assign out_dout    = out_dout_r;
    assign word_count  = word_count_r;
    assign checksum    = checksum_r;
    assign flush_count = flush_count_r;

endmodule
